y86_stage_sequencer: RTL
========================

# y86_stage_sequencer

Multi-cycle control unit for the sequential Y86-64 core. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, and issues a one-cycle enable to each stage datapath block. It gates condition-code writes into the execute stage, holds the memory stage on a ready handshake, and tracks processor status (AOK/HLT/ADR/INS) until the core halts.

## Interface
Parameters:
- CNT_W, 32, width of cycle and instruction counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin execution from IDLE; ignored in all other states
- icode  in  4  instruction code from the fetch stage; sampled at end of FETCH
- imem_error  in  1  fetch address invalid; sampled at end of FETCH
- mem_ready  in  1  data memory completes the current access this cycle
- dmem_error  in  1  data access invalid; valid only when mem_ready=1
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  out  1 each  stage enables, registered
- cc_write_en  out  1  condition-code update strobe to execute
- mem_read, mem_write  out  1 each  memory request type, held high through MEMORY until mem_ready
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  high in any state except IDLE and HALT
- cycle_count  out  CNT_W  cycles spent outside IDLE/HALT
- instr_count  out  CNT_W  instructions retired

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: fetch_en=1. At the clock edge, latch icode into icode_q. Priority order:
  - imem_error=1 -> HALT, stat=ADR.
  - icode > 4'hB -> HALT, stat=INS.
  - icode=0 -> HALT, stat=HLT.
  - otherwise -> DECODE.
- DECODE -> EXECUTE -> MEMORY: one cycle each.
- EXECUTE: execute_en=1. cc_write_en=1 only when icode_q=6 (OPq).
- MEMORY: memory_en=1.
  - mem_read=1 for icode_q in {5,9,B}.
  - mem_write=1 for icode_q in {4,8,A}.
  - Other icodes: no request; leave after 1 cycle.
  - Accessing icodes: stay in MEMORY until mem_ready=1.
  - mem_ready=1 with dmem_error=1 -> HALT, stat=ADR; no writeback or PC update.
  - mem_ready=1 with dmem_error=0 -> WRITEBACK.
- WRITEBACK: writeback_en=1 only for icode_q in {2,3,5,6,8,9,A,B}. The state always lasts 1 cycle, then -> PCUPD.
- PCUPD: pc_en=1; instr_count += 1; -> FETCH.
- HALT: terminal state. All enables 0, stat held. Exits only on reset.
- cycle_count increments on every cycle in FETCH..PCUPD. Both counters wrap modulo 2^CNT_W.

## Timing
- Reset values: state=IDLE, all enables/strobes 0, mem_read=mem_write=0, stat=1 (AOK), busy=0, counters 0, icode_q=0.
- Reset asserted mid-instruction, including during a MEMORY wait: on the next edge the block returns to the full reset state. Any pending memory request drops in the same cycle reset takes effect.
- All outputs are registered and decoded from the current state and icode_q. Each stage enable is high for exactly the cycles spent in its state.
- Latency:
  - Non-memory instruction: 6 cycles, FETCH to PCUPD inclusive.
  - Memory instruction: 6 + N cycles, where N = cycles with mem_ready=0 in MEMORY.
  - Halt/invalid/imem_error: FETCH lasts 1 cycle, then HALT.
- start held high outside IDLE has no effect. start and reset asserted together: reset wins.
- mem_ready asserted outside MEMORY, or for a non-accessing icode, is ignored. dmem_error is ignored unless mem_ready=1 in an accessing MEMORY cycle.

## Test plan
- Reset, start, irmovq (icode=3, mem_ready tied 1) -> enables strobe in order over 6 cycles; cc_write_en=0; writeback_en=1; instr_count=1, cycle_count=6, stat=1.
- OPq (icode=6) -> cc_write_en=1 only in the EXECUTE cycle; no mem_read/mem_write.
- mrmovq (icode=5), mem_ready low for 3 MEMORY cycles then high -> mem_read high 4 cycles; instruction retires in 9 cycles.
- rmmovq (icode=4) with mem_ready=1, dmem_error=1 -> HALT, stat=3, no pc_en, instr_count unchanged.
- Fetch icode=0 -> HALT, stat=2, busy=0. Fetch icode=C -> stat=4. imem_error=1 with icode=3 -> stat=3.
- reset during a MEMORY wait of pushq (icode=A) -> next cycle IDLE, mem_write=0, counters 0, stat=1; a new start then runs normally.

Source files
------------

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle sequencer for the sequential Y86-64 core: walks each instruction
// through FETCH..PCUPD, strobes the stage enables and tracks processor status.
module y86_stage_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic             cc_write_en,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t     state, state_d;
    logic [3:0] icode_q, icode_d;
    logic [2:0] stat_d;
    logic       fetch_d, decode_d, execute_d, memory_d, writeback_d, pc_d;
    logic       cc_d, rd_d, wr_d, busy_d;
    logic       cur_rd, cur_wr;

    function automatic logic is_rd(input logic [3:0] c);
        return (c == 4'h5) || (c == 4'h9) || (c == 4'hB);
    endfunction

    function automatic logic is_wr(input logic [3:0] c);
        return (c == 4'h4) || (c == 4'h8) || (c == 4'hA);
    endfunction

    function automatic logic is_wb(input logic [3:0] c);
        return (c == 4'h2) || (c == 4'h3) || (c == 4'h5) || (c == 4'h6) ||
               (c == 4'h8) || (c == 4'h9) || (c == 4'hA) || (c == 4'hB);
    endfunction

    assign cur_rd = is_rd(icode_q);
    assign cur_wr = is_wr(icode_q);

    // State, icode latch, counters and the registered outputs share one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            icode_q      <= 4'h0;
            stat         <= STAT_AOK;
            fetch_en     <= 1'b0;
            decode_en    <= 1'b0;
            execute_en   <= 1'b0;
            memory_en    <= 1'b0;
            writeback_en <= 1'b0;
            pc_en        <= 1'b0;
            cc_write_en  <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            busy         <= 1'b0;
            cycle_count  <= '0;
            instr_count  <= '0;
        end else begin
            state        <= state_d;
            icode_q      <= icode_d;
            stat         <= stat_d;
            fetch_en     <= fetch_d;
            decode_en    <= decode_d;
            execute_en   <= execute_d;
            memory_en    <= memory_d;
            writeback_en <= writeback_d;
            pc_en        <= pc_d;
            cc_write_en  <= cc_d;
            mem_read     <= rd_d;
            mem_write    <= wr_d;
            busy         <= busy_d;
            if (state != IDLE && state != HALT)
                cycle_count <= cycle_count + 1'b1;
            if (state == PCUPD)
                instr_count <= instr_count + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        stat_d  = stat;
        icode_d = icode_q;
        unique case (state)
            IDLE:    if (start) state_d = FETCH;
            FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    state_d = HALT;
                    stat_d  = STAT_ADR;
                end else if (icode > 4'hB) begin
                    state_d = HALT;
                    stat_d  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_d = HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = MEMORY;
            MEMORY: begin
                if (!(cur_rd || cur_wr)) begin
                    state_d = WRITEBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        state_d = HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
            end
            WRITEBACK: state_d = PCUPD;
            PCUPD:     state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered strobe
    // lines up with the cycle actually spent in that state.
    always_comb begin
        fetch_d     = (state_d == FETCH);
        decode_d    = (state_d == DECODE);
        execute_d   = (state_d == EXECUTE);
        memory_d    = (state_d == MEMORY);
        writeback_d = (state_d == WRITEBACK) && is_wb(icode_d);
        pc_d        = (state_d == PCUPD);
        cc_d        = (state_d == EXECUTE) && (icode_d == 4'h6);
        rd_d        = (state_d == MEMORY) && is_rd(icode_d);
        wr_d        = (state_d == MEMORY) && is_wr(icode_d);
        busy_d      = (state_d != IDLE) && (state_d != HALT);
    end

endmodule
